// File: rtl/soc_system_ocram_pipe_if.sv
// Bus bundle for the on-chip RAM: port A (read/write, stallable),
// port B (read-only display fetch) and the clear control.
interface soc_system_ocram_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    b_read;
  logic [ADDR_WIDTH-1:0]   b_address;
  logic [DATA_WIDTH-1:0]   b_readdata;
  logic                    b_readdatavalid;
  logic                    clear_req;
  logic                    clear_busy;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    output b_read, b_address, clear_req,
    input  readdata, readdatavalid, waitrequest,
    input  b_readdata, b_readdatavalid, clear_busy
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    input  b_read, b_address, clear_req,
    output readdata, readdatavalid, waitrequest,
    output b_readdata, b_readdatavalid, clear_busy
  );
endinterface

// File: rtl/soc_system_ocram_pipe.sv
// Dual-port on-chip RAM with pipelined reads (latency 1 or 2), byte-lane
// writes on port A, and a one-word-per-cycle clear engine that stalls port A.
module soc_system_ocram_pipe #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    READ_LATENCY   = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  soc_system_ocram_pipe_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  w_busy, w_acc_rd, w_acc_wr;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [READ_LATENCY:1]                 r_a_vld, r_b_vld;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] r_a_dat, r_b_dat;

  assign w_busy   = (r_state == CLEAR);
  // A simultaneous read+write is treated as a write only.
  assign w_acc_wr = bus.chipselect & bus.write & ~w_busy;
  assign w_acc_rd = bus.chipselect & bus.read & ~bus.write & ~w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= CLEAR_VALUE;
    end else if (w_acc_wr) begin
      for (int i = 0; i < NBYTES; i++)
        if (bus.byteenable[i])
          r_mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
    end
  end

  // Read pipes: stage data only moves with its valid, so outputs hold.
  // Reads sample pre-write contents, giving old data on a same-cycle collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_vld <= '0;
      r_a_dat <= '0;
      r_b_vld <= '0;
      r_b_dat <= '0;
    end else begin
      r_a_vld[1] <= w_acc_rd;
      if (w_acc_rd) r_a_dat[1] <= r_mem[bus.address];
      r_b_vld[1] <= bus.b_read;
      if (bus.b_read) r_b_dat[1] <= r_mem[bus.b_address];
      for (int s = 2; s <= READ_LATENCY; s++) begin
        r_a_vld[s] <= r_a_vld[s-1];
        if (r_a_vld[s-1]) r_a_dat[s] <= r_a_dat[s-1];
        r_b_vld[s] <= r_b_vld[s-1];
        if (r_b_vld[s-1]) r_b_dat[s] <= r_b_dat[s-1];
      end
    end
  end

  assign bus.readdata        = r_a_dat[READ_LATENCY];
  assign bus.readdatavalid   = r_a_vld[READ_LATENCY];
  assign bus.b_readdata      = r_b_dat[READ_LATENCY];
  assign bus.b_readdatavalid = r_b_vld[READ_LATENCY];
  assign bus.waitrequest     = w_busy;
  assign bus.clear_busy      = w_busy;
endmodule

// File: tb/tb_soc_system_ocram_pipe.sv
// Scoreboarded bench: a cycle-level memory model predicts read responses,
// a negedge monitor compares them against both DUT read ports.
module tb_soc_system_ocram_pipe;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  soc_system_ocram_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus();

  soc_system_ocram_pipe #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(LAT),
    .CLEAR_VALUE(16'h0000), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [15:0] d; int due; } exp_t;
  exp_t exp_a[$];
  exp_t exp_b[$];

  logic [15:0] mem [256];
  bit          m_busy = 1'b1;
  int          m_cnt  = 0;
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_err  = 0;
  logic [15:0] last_a = '0, last_b = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: memory array plus a clear countdown, evaluated per clock.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end else begin
        if (bus.b_read) exp_b.push_back('{mem[bus.b_address], cyc + LAT - 1});
        if (bus.chipselect && (bus.read || bus.write) && !m_busy) begin
          if (bus.write) begin
            for (int l = 0; l < 2; l++)
              if (bus.byteenable[l]) mem[bus.address][8*l +: 8] = bus.writedata[8*l +: 8];
          end else begin
            exp_a.push_back('{mem[bus.address], cyc + LAT - 1});
          end
        end
        if (m_busy) begin
          mem[m_cnt] = 16'h0000;
          if (m_cnt == 255) m_busy = 1'b0;
          m_cnt = (m_cnt + 1) % 256;
        end else if (bus.clear_req) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_rdv",   bus.readdatavalid, 0);
        chk("rst_brdv",  bus.b_readdatavalid, 0);
        chk("rst_rd",    bus.readdata, 0);
        chk("rst_brd",   bus.b_readdata, 0);
        chk("rst_wait",  bus.waitrequest, 1);
        chk("rst_busy",  bus.clear_busy, 1);
        exp_a.delete();
        exp_b.delete();
        last_a = '0;
        last_b = '0;
      end else begin
        chk("waitrequest", bus.waitrequest, m_busy);
        chk("clear_busy",  bus.clear_busy, m_busy);
        if (bus.readdatavalid) begin
          if (exp_a.size() == 0) chk("a_unexpected_valid", 1, 0);
          else begin
            e = exp_a.pop_front();
            chk("a_latency", cyc, e.due);
            chk("a_data", bus.readdata, e.d);
            last_a = e.d;
          end
        end else begin
          if (exp_a.size() != 0 && exp_a[0].due <= cyc) begin
            chk("a_missing_valid", 0, 1);
            void'(exp_a.pop_front());
          end
          chk("a_hold", bus.readdata, last_a);
        end
        if (bus.b_readdatavalid) begin
          if (exp_b.size() == 0) chk("b_unexpected_valid", 1, 0);
          else begin
            e = exp_b.pop_front();
            chk("b_latency", cyc, e.due);
            chk("b_data", bus.b_readdata, e.d);
            last_b = e.d;
          end
        end else begin
          if (exp_b.size() != 0 && exp_b[0].due <= cyc) begin
            chk("b_missing_valid", 0, 1);
            void'(exp_b.pop_front());
          end
          chk("b_hold", bus.b_readdata, last_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a port A request and hold it until the edge that accepts it.
  task automatic a_issue(input bit wr, input logic [7:0] a, input logic [15:0] d,
                         input logic [1:0] be);
    bit ok = 1'b0;
    bit w;
    bus.chipselect = 1'b1; bus.read = ~wr; bus.write = wr;
    bus.address = a; bus.writedata = d; bus.byteenable = be;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); w = bus.waitrequest;
      @(posedge clk); #1;
      if (!w) begin ok = 1'b1; break; end
    end
    chk("a_accept", ok, 1);
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
  endtask

  // Count negedges with waitrequest high; optionally pulse clear_req mid-way.
  task automatic busy_len(input bit repulse, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      n++;
      if (repulse && n == 50) bus.clear_req = 1'b1;
      if (repulse && n == 51) bus.clear_req = 1'b0;
    end
  endtask

  initial begin
    int n;
    bit w;
    bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = '0;
    bus.byteenable = '0; bus.writedata = '0; bus.b_read = 0; bus.b_address = '0;
    bus.clear_req = 0;

    repeat (3) step();
    reset = 1'b0;
    busy_len(1'b0, n);
    chk("busy_after_reset", n, 256);
    step();

    a_issue(1'b0, 8'h00, '0, '0);
    a_issue(1'b0, 8'hFF, '0, '0);

    a_issue(1'b1, 8'h10, 16'h1234, 2'b11);
    a_issue(1'b1, 8'h10, 16'hABCD, 2'b01);
    a_issue(1'b0, 8'h10, '0, '0);

    a_issue(1'b1, 8'h01, 16'h0101, 2'b11);
    a_issue(1'b1, 8'h02, 16'h0202, 2'b11);
    a_issue(1'b1, 8'h03, 16'h0303, 2'b11);
    a_issue(1'b0, 8'h01, '0, '0);
    a_issue(1'b0, 8'h02, '0, '0);
    a_issue(1'b0, 8'h03, '0, '0);

    // Same-cycle port A write and port B read of one address, then re-read.
    bus.b_read = 1'b1; bus.b_address = 8'h20;
    a_issue(1'b1, 8'h20, 16'h5555, 2'b11);
    step();
    bus.b_read = 1'b0;
    repeat (3) step();

    // Clear with a held port A read and a second ignored clear_req.
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    fork
      a_issue(1'b0, 8'h10, '0, '0);
      begin
        busy_len(1'b1, n);
        chk("busy_after_clear_req", n, 256);
      end
    join
    repeat (3) step();

    // Randomized traffic.
    a_issue(1'b1, 8'h05, 16'hBEEF, 2'b11);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); w = bus.waitrequest;
      @(posedge clk); #1;
      bus.b_read    = $urandom_range(0, 1);
      bus.b_address = 8'($urandom_range(0, 15));
      bus.clear_req = ($urandom_range(0, 249) == 0);
      if (!w) begin
        bus.chipselect = ($urandom_range(0, 3) != 0);
        bus.read       = $urandom_range(0, 1);
        bus.write      = $urandom_range(0, 1);
        bus.address    = 8'($urandom_range(0, 15));
        bus.writedata  = 16'($urandom);
        bus.byteenable = 2'($urandom_range(0, 3));
      end
    end
    bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.b_read = 0; bus.clear_req = 0;
    for (int k = 0; k < 400 && bus.waitrequest; k++) step();
    repeat (3) step();

    // Read in flight as clear begins completes; then reset mid-clear kills a port B read.
    a_issue(1'b1, 8'h07, 16'h7777, 2'b11);
    bus.clear_req = 1'b1;
    a_issue(1'b0, 8'h07, '0, '0);
    bus.clear_req = 1'b0;
    repeat (99) step();
    bus.b_read = 1'b1; bus.b_address = 8'h07;
    step();
    bus.b_read = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    busy_len(1'b0, n);
    chk("busy_after_midclear_reset", n, 256);
    step();
    a_issue(1'b0, 8'h07, '0, '0);
    a_issue(1'b0, 8'h10, '0, '0);
    bus.b_read = 1'b1; bus.b_address = 8'h05;
    step();
    bus.b_read = 1'b0;
    repeat (6) step();

    chk("a_drain", exp_a.size(), 0);
    chk("b_drain", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/soc_system_ocram_pipe.md
SOC_SYSTEM_OCRAM_PIPE -- requirements
Module: soc_system_ocram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 2, legal values 1 or 2; cycles from read acceptance to readdatavalid.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit fill word.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = run clear sequence after reset release.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 chipselect  input  1  port A select.
REQ-009 read  input  1  port A read request.
REQ-010 write  input  1  port A write request.
REQ-011 address  input  ADDR_WIDTH  port A word address.
REQ-012 byteenable  input  DATA_WIDTH/8  port A byte lanes for writes.
REQ-013 writedata  input  DATA_WIDTH  port A write data.
REQ-014 readdata  output  DATA_WIDTH  port A read data.
REQ-015 readdatavalid  output  1  port A read data qualifier.
REQ-016 waitrequest  output  1  port A stall.
REQ-017 b_read  input  1  port B (read-only, display fetch) request.
REQ-018 b_address  input  ADDR_WIDTH  port B word address.
REQ-019 b_readdata  output  DATA_WIDTH  port B read data.
REQ-020 b_readdatavalid  output  1  port B read data qualifier.
REQ-021 clear_req  input  1  single-cycle pulse: start clear sequence.
REQ-022 clear_busy  output  1  high while clear sequence runs.

Function
REQ-023 SHALL hold DEPTH x DATA_WIDTH storage, inferable as true dual-port block RAM; contents not affected by reset.
REQ-024 SHALL implement FSM states IDLE and CLEAR; waitrequest = clear_busy = (state == CLEAR).
REQ-025 Port A access SHALL be accepted when chipselect & (read | write) & ~waitrequest.
REQ-026 Accepted write SHALL update only lanes with byteenable[i]=1 at end of acceptance cycle; byteenable=0 is a legal no-op write.
REQ-027 Simultaneous read and write accepted SHALL perform write only; no readdatavalid generated.
REQ-028 Accepted read SHALL assert readdatavalid for one cycle exactly READ_LATENCY cycles after acceptance, with readdata = word at address; back-to-back reads every cycle SHALL be supported (fully pipelined).
REQ-029 readdata/b_readdata SHALL hold last value when valid is low.
REQ-030 Port B read (b_read=1) SHALL always be accepted, including during CLEAR, with b_readdatavalid READ_LATENCY cycles later.
REQ-031 Port B read and port A write to same address in same cycle SHALL return old data on port B; port A read of an address written in the prior cycle SHALL return new data.
REQ-032 clear_req in IDLE SHALL enter CLEAR next cycle with counter = 0; clear_req in CLEAR SHALL be ignored.
REQ-033 CLEAR SHALL write CLEAR_VALUE to word counter, all lanes, one word per cycle, counter+1; after writing word DEPTH-1 state SHALL return to IDLE (exactly DEPTH cycles busy).
REQ-034 Port A requests during CLEAR SHALL be stalled (not accepted), held by master until waitrequest low.
REQ-035 Read pipeline stages already in flight when CLEAR starts SHALL complete normally.

Reset
REQ-036 On reset: readdatavalid=0, b_readdatavalid=0, readdata=0, b_readdata=0, pipeline valid bits cleared, clear counter=0.
REQ-037 On reset: state = CLEAR if CLEAR_ON_RESET=1 (waitrequest=clear_busy=1), else IDLE (both 0).
REQ-038 Reset asserted mid-CLEAR or mid-read SHALL abort in-flight reads (no valid emitted) and restart per REQ-037.

Verification (DATA_WIDTH=16, ADDR_WIDTH=8, READ_LATENCY=2, CLEAR_ON_RESET=1)
REQ-039 Release reset -> waitrequest=1 for exactly 256 cycles, then 0; read addr 0x00 and 0xFF -> 0x0000 each, valid 2 cycles after acceptance.
REQ-040 Write 0x1234 to 0x10 with byteenable=2'b11, then write 0xABCD with byteenable=2'b01 -> read 0x10 returns 0x12CD.
REQ-041 Reads to 0x01,0x02,0x03 on consecutive cycles after writing 0x0101,0x0202,0x0303 -> readdatavalid high 3 consecutive cycles with data in order.
REQ-042 Port A write 0x5555 to 0x20 and port B read 0x20 same cycle (old 0x0000) -> b_readdata=0x0000; next port B read -> 0x5555.
REQ-043 clear_req pulse while port A read held on chipselect -> read stalled 256 cycles, then accepted and returns 0x0000; second clear_req during CLEAR does not extend busy.
REQ-044 Assert reset at clear counter=100 -> busy restarts, deasserts 256 cycles after reset release; in-flight read produces no readdatavalid.
